if_prefetch_queue: RTL and testbench
====================================

// Module: if_prefetch_queue
// PURPOSE
//  Instruction prefetch FIFO between the IF stage and the IF/ID register.
//  IF pushes {PC+4, instruction} each cycle it has room; IF/ID pops one entry when IF_ID_Write=1.
//  Flush (taken branch/jump resolved in ID) discards all prefetched entries.
//  Stalls from HazardDetect (IF_ID_Write=0) no longer freeze IF while the queue has space.
// PARAMETERS
//  DEPTH   4   number of entries; power of two, 2..16
//  PTR_W   2   log2(DEPTH); pointer width (count width is PTR_W+1)
// PORTS
//  clock              in   1   CPU clock; all state updates on rising edge
//  reset              in   1   asynchronous, active-high; clears queue
//  push_valid         in   1   IF presents a fetched instruction this cycle
//  push_ready         out  1   queue can accept a push this cycle
//  push_pc_plus_four  in   32  PC+4 of fetched instruction
//  push_instruction   in   32  fetched instruction word
//  pop                in   1   IF/ID consumes head entry (driven by IF_ID_Write)
//  flush              in   1   discard all entries (driven by Flush)
//  out_valid          out  1   head entry present
//  out_pc_plus_four   out  32  head PC+4; 0 when out_valid=0
//  out_instruction    out  32  head instruction; 32'h0000_0000 (NOP) when out_valid=0
//  count              out  3   entries held, 0..DEPTH (PTR_W+1 bits)
// BEHAVIOUR
//  - Reset (async, any time incl. mid-operation): rd_ptr=0, wr_ptr=0, count=0;
//    out_valid=0, out_* = 0, push_ready=1 immediately, without waiting for a clock edge.
//  - Storage: circular buffer, DEPTH x 64 bits; pointers wrap DEPTH-1 -> 0 (modulo DEPTH).
//  - First-word fall-through: out_* show the head entry combinationally from storage;
//    a pushed entry appears on out_* the cycle after its push edge (latency 1).
//  - push_ready = (count != DEPTH); depends only on registered state, not on pop.
//  - Push accepted at an edge iff push_valid & push_ready & ~flush: write at wr_ptr, wr_ptr++.
//  - Pop accepted at an edge iff pop & out_valid & ~flush: rd_ptr++.
//  - count next = count + push_acc - pop_acc; simultaneous push+pop leaves count unchanged.
//  - Pop when empty: ignored, no pointer movement, no underflow.
//  - Push when full: ignored; IF must hold PC while push_ready=0.
//  - flush=1 at an edge: rd_ptr <= wr_ptr, count <= 0; any same-cycle push and pop are dropped.
//    Next cycle: out_valid=0 and out_instruction=NOP.
//  - Storage contents are not cleared by reset or flush; only the pointers and count change.
//  - State is empty/partial/full, derived from count; no separate FSM register.
//    Transitions happen only through the push/pop/flush rules above.
// TESTING
//  1 Reset: assert reset between edges -> out_valid=0, count=0, push_ready=1, out_instruction=0
//    with no clock edge needed.
//  2 FWFT latency: push {4, 32'h2008_0005} with pop=0 -> next cycle out_valid=1,
//    out_instruction=32'h2008_0005, out_pc_plus_four=4, count=1.
//  3 Full/wrap: push 6 words (PC+4 = 4,8,..,24) with pop=0 -> count=4 and push_ready=0
//    after the 4th push; pushes 5-6 dropped; pop 4 -> PC+4 = 4,8,12,16 in order.
//    Push 3 more -> wr_ptr wraps, order preserved.
//  4 Simultaneous push+pop at count=2 -> count stays 2; head advances one entry.
//    Same at count=4 -> push rejected, count=3.
//  5 Flush: count=3, flush=1 with push_valid=1 and pop=1 -> next cycle count=0, out_valid=0,
//    out_instruction=0; the following push appears alone, one cycle later.
//  6 Pop when empty (count=0, pop=1 for 3 cycles) -> count stays 0, pointers unchanged.
//    Reset asserted mid-burst with count=3 -> count=0 asynchronously.

Source files
------------

// File: rtl/if_prefetch_queue_if.sv
// Handshake bundle between the IF stage, the prefetch queue and the IF/ID register.
// The slave modport is the queue; the master modport is whoever drives fetch and consume.
interface if_prefetch_queue_if #(
    parameter int PTR_W = 2
) ();
    logic             push_valid;
    logic             push_ready;
    logic [31:0]      push_pc_plus_four;
    logic [31:0]      push_instruction;
    logic             pop;
    logic             flush;
    logic             out_valid;
    logic [31:0]      out_pc_plus_four;
    logic [31:0]      out_instruction;
    logic [PTR_W:0]   count;

    modport slave (
        input  push_valid,
        input  push_pc_plus_four,
        input  push_instruction,
        input  pop,
        input  flush,
        output push_ready,
        output out_valid,
        output out_pc_plus_four,
        output out_instruction,
        output count
    );

    modport master (
        output push_valid,
        output push_pc_plus_four,
        output push_instruction,
        output pop,
        output flush,
        input  push_ready,
        input  out_valid,
        input  out_pc_plus_four,
        input  out_instruction,
        input  count
    );
endinterface

// File: rtl/if_prefetch_queue.sv
// Instruction prefetch FIFO (first-word fall-through) between IF and the IF/ID register.
// Lets IF keep fetching through ID stalls; a flush drops everything prefetched.
module if_prefetch_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    if_prefetch_queue_if.slave   q
);
    typedef enum logic [1:0] {
        FILL_EMPTY,
        FILL_PARTIAL,
        FILL_FULL
    } fill_e;

    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [63:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    fill_e            fill;
    logic             push_ready;
    logic             out_valid;
    logic             push_acc;
    logic             pop_acc;
    logic [63:0]      head;

    // Occupancy class is purely a view of count; there is no separate state register.
    always_comb begin
        fill = FILL_PARTIAL;
        if (count_q == '0) begin
            fill = FILL_EMPTY;
        end else if (count_q == FULL_CNT) begin
            fill = FILL_FULL;
        end
    end

    assign push_ready = (fill != FILL_FULL);
    assign out_valid  = (fill != FILL_EMPTY);

    // Flush wins over both handshakes so a redirect never lets a stale entry through.
    assign push_acc = q.push_valid & push_ready & ~q.flush;
    assign pop_acc  = q.pop & out_valid & ~q.flush;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (q.flush) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (push_acc) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop_acc) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            case ({push_acc, pop_acc})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is intentionally not reset; pointers and count alone define validity.
    always_ff @(posedge clock) begin
        if (push_acc) begin
            mem_q[wr_ptr_q] <= {q.push_pc_plus_four, q.push_instruction};
        end
    end

    assign head = mem_q[rd_ptr_q];

    assign q.push_ready       = push_ready;
    assign q.out_valid        = out_valid;
    assign q.out_pc_plus_four = out_valid ? head[63:32] : 32'h0000_0000;
    assign q.out_instruction  = out_valid ? head[31:0]  : 32'h0000_0000;
    assign q.count            = count_q;
endmodule

// File: tb/tb_if_prefetch_queue.sv
// Directed bench for if_prefetch_queue: reset, FWFT latency, full/wrap, push+pop, flush, empty pop.
module tb_if_prefetch_queue;
    logic clock;
    logic reset;
    int   checks;
    int   failures;

    if_prefetch_queue_if #(.PTR_W(2)) q ();

    if_prefetch_queue #(.DEPTH(4), .PTR_W(2)) dut (
        .clock (clock),
        .reset (reset),
        .q     (q)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic pv, input logic [31:0] pc, input logic pp, input logic fl);
        q.push_valid        = pv;
        q.push_pc_plus_four = pc;
        q.push_instruction  = 32'hA000_0000 | pc;
        q.pop               = pp;
        q.flush             = fl;
    endtask

    task automatic chk_head(input string tag, input logic [31:0] pc, input logic [2:0] cnt);
        chk({tag, "_valid"}, 64'(q.out_valid), 64'd1);
        chk({tag, "_pc"},    64'(q.out_pc_plus_four), 64'(pc));
        chk({tag, "_instr"}, 64'(q.out_instruction), 64'(32'hA000_0000 | pc));
        chk({tag, "_count"}, 64'(q.count), 64'(cnt));
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, "_valid"}, 64'(q.out_valid), 64'd0);
        chk({tag, "_count"}, 64'(q.count), 64'd0);
        chk({tag, "_ready"}, 64'(q.push_ready), 64'd1);
        chk({tag, "_instr"}, 64'(q.out_instruction), 64'd0);
        chk({tag, "_pc"},    64'(q.out_pc_plus_four), 64'd0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        drive(1'b0, 32'd0, 1'b0, 1'b0);

        // 1: asynchronous reset, observed before any clock edge
        reset = 1'b1;
        #2;
        chk_empty("rst_async");
        tick();
        reset = 1'b0;
        tick();

        // 2: FWFT latency
        q.push_valid        = 1'b1;
        q.push_pc_plus_four = 32'd4;
        q.push_instruction  = 32'h2008_0005;
        tick();
        q.push_valid = 1'b0;
        chk("fwft_valid", 64'(q.out_valid), 64'd1);
        chk("fwft_instr", 64'(q.out_instruction), 64'h2008_0005);
        chk("fwft_pc",    64'(q.out_pc_plus_four), 64'd4);
        chk("fwft_count", 64'(q.count), 64'd1);
        q.pop = 1'b1;
        tick();
        q.pop = 1'b0;
        chk_empty("fwft_drain");

        // 3: fill to full, drop extra pushes, drain in order
        for (int i = 1; i <= 6; i++) begin
            drive(1'b1, 32'(4 * i), 1'b0, 1'b0);
            tick();
            if (i == 4) begin
                chk("full_count", 64'(q.count), 64'd4);
                chk("full_ready", 64'(q.push_ready), 64'd0);
            end
        end
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        chk("full_hold_count", 64'(q.count), 64'd4);
        for (int i = 1; i <= 4; i++) begin
            chk_head("drain", 32'(4 * i), 3'(5 - i));
            q.pop = 1'b1;
            tick();
            q.pop = 1'b0;
        end
        chk_empty("drain_done");

        // 3b: write pointer wraps 1 -> 2 -> 3 -> 0
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'(28 + 4 * i), 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk_head("wrap", 32'(28 + 4 * i), 3'(3 - i));
            q.pop = 1'b1;
            tick();
            q.pop = 1'b0;
        end
        chk_empty("wrap_done");

        // 4: simultaneous push+pop at count=2 and at count=4
        drive(1'b1, 32'd40, 1'b0, 1'b0); tick();
        drive(1'b1, 32'd44, 1'b0, 1'b0); tick();
        drive(1'b1, 32'd48, 1'b1, 1'b0); tick();
        chk_head("pp2", 32'd44, 3'd2);
        drive(1'b1, 32'd52, 1'b0, 1'b0); tick();
        drive(1'b1, 32'd56, 1'b0, 1'b0); tick();
        chk("pp4_ready", 64'(q.push_ready), 64'd0);
        drive(1'b1, 32'd60, 1'b1, 1'b0); tick();
        chk_head("pp4", 32'd48, 3'd3);

        // 5: flush with same-cycle push and pop
        drive(1'b1, 32'd64, 1'b1, 1'b1); tick();
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        chk_empty("flush");
        drive(1'b1, 32'd68, 1'b0, 1'b0); tick();
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        chk_head("post_flush", 32'd68, 3'd1);
        q.pop = 1'b1; tick(); q.pop = 1'b0;

        // 6: pops while empty must not move the read pointer
        q.pop = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("empty_pop_count", 64'(q.count), 64'd0);
            chk("empty_pop_valid", 64'(q.out_valid), 64'd0);
        end
        q.pop = 1'b0;
        drive(1'b1, 32'd72, 1'b0, 1'b0); tick();
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        chk_head("after_empty_pop", 32'd72, 3'd1);

        // 6b: reset asserted between edges with count=3
        drive(1'b1, 32'd76, 1'b0, 1'b0); tick();
        drive(1'b1, 32'd80, 1'b0, 1'b0); tick();
        chk("pre_rst_count", 64'(q.count), 64'd3);
        reset = 1'b1;
        #1;
        chk_empty("rst_mid");
        #1;
        reset = 1'b0;
        drive(1'b1, 32'd84, 1'b0, 1'b0); tick();
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        chk_head("post_rst", 32'd84, 3'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
